// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter and the debug block that talks to it.
package dmem_pkg;

    localparam int DMEM_DATA_W = 24;
    localparam int DMEM_ADDR_W = 8;

    // Requester IDs, also used to tag which port an outstanding read belongs to.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/starve_cnt.sv
// Saturating count of consecutive cycles the debug port was denied.
// at_limit tells the arbiter to force the debug request through.
module starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign at_limit = (cnt_q == CW'(LIMIT));

    // NOTE: cnt_d gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_limit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Fixed-priority CPU/debug arbiter for the single-port data memory, with a
// starvation guarantee for debug and routing of synchronous read data.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_W       = DMEM_DATA_W,
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic force_dbg;
    logic rd_pend_q, rd_pend_d;
    logic rd_owner_q, rd_owner_d;
    logic rd_valid;

    starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (dbg_req & ~dbg_gnt),
        .clr      (~dbg_req | dbg_gnt),
        .at_limit (force_dbg)
    );

    // Grants are held off while reset is asserted so nothing reaches memory.
    always_comb begin
        dbg_gnt   = rst_n & dbg_req & (~cpu_req | force_dbg);
        cpu_gnt   = rst_n & cpu_req & ~dbg_gnt;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dbg_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    always_comb begin
        rd_pend_d  = mem_en & ~mem_we;
        rd_owner_d = rd_owner_q;
        if (rd_pend_d) begin
            rd_owner_d = dbg_gnt ? REQ_DBG : REQ_CPU;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= REQ_CPU;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // A read whose data would land during reset is dropped, not delivered.
    assign rd_valid   = rd_pend_q & rst_n;
    assign cpu_rvalid = rd_valid & (rd_owner_q == REQ_CPU);
    assign dbg_rvalid = rd_valid & (rd_owner_q == REQ_DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle grant/command checks plus a
// scoreboard that matches every read return to the port and cycle expected.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [7:0]  cpu_addr, dbg_addr;
    logic [23:0] cpu_wdata, dbg_wdata;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [23:0] cpu_rdata, dbg_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [23:0] mem_wdata, mem_rdata;

    typedef struct {
        logic        owner;
        logic [23:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    dmem_arbiter #(.DATA_W(24), .ADDR_W(8), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: word i starts as i*0x11; synchronous read, write at the edge.
    initial begin
        logic [23:0] mem [256];
        for (int i = 0; i < 256; i++) mem[i] = 24'(i * 17);
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) mem[mem_addr] = mem_wdata;
                else        mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every rvalid must match the oldest pending expectation exactly.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rv_missing @cyc %0d: no rvalid, want port %0d data %h at cyc %0d",
                     cyc, sb[0].owner, sb[0].data, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (cpu_rvalid === 1'b1 || dbg_rvalid === 1'b1) begin
            if (sb.size() == 0 || sb[0].cyc != cyc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rv_unexpected @cyc %0d: got cpu_rvalid=%b dbg_rvalid=%b want none",
                         cyc, cpu_rvalid, dbg_rvalid);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rv_port", 64'({cpu_rvalid, dbg_rvalid}), (e.owner == REQ_DBG) ? 64'h1 : 64'h2);
                check("rv_data",
                      (e.owner == REQ_DBG) ? 64'({dbg_rdata, cpu_rdata}) : 64'({cpu_rdata, dbg_rdata}),
                      64'({e.data, 24'h0}));
            end
        end
    end

    // One clock cycle with the inputs already driven: check grants and memory
    // command, optionally expect a read return next cycle.
    task automatic cycle(input logic exp_c, input logic exp_d,
                         input logic [23:0] exp_rd, input bit ret);
        logic [33:0] exp_mem;
        @(negedge clk);
        exp_mem = '0;
        if (exp_d)      exp_mem = {1'b1, dbg_we, dbg_addr, dbg_wdata};
        else if (exp_c) exp_mem = {1'b1, cpu_we, cpu_addr, cpu_wdata};
        check("gnt", 64'({cpu_gnt, dbg_gnt}), 64'({exp_c, exp_d}));
        check("mem_cmd", 64'({mem_en, mem_we, mem_addr, mem_wdata}), 64'(exp_mem));
        if (!rst_n) check("rst_rvalid", 64'({cpu_rvalid, dbg_rvalid}), 64'h0);
        if (ret) sb.push_back('{owner: exp_d ? REQ_DBG : REQ_CPU, data: exp_rd, cyc: cyc + 1});
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_drive(input logic req, input logic we, input logic [7:0] a, input logic [23:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic dbg_drive(input logic req, input logic we, input logic [7:0] a, input logic [23:0] d);
        dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_drive(1'b1, 1'b0, 8'h03, 24'h0);
        dbg_drive(1'b0, 1'b0, 8'h00, 24'h0);

        // Reset held with the CPU requesting: nothing granted, nothing returned.
        repeat (2) cycle(1'b0, 1'b0, 24'h0, 1'b0);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 24'h000033, 1'b1);

        // CPU write then read-back of the same address.
        cpu_drive(1'b1, 1'b1, 8'h05, 24'h00ABCD);
        cycle(1'b1, 1'b0, 24'h0, 1'b0);
        cpu_drive(1'b1, 1'b0, 8'h05, 24'h0);
        cycle(1'b1, 1'b0, 24'h00ABCD, 1'b1);
        cpu_drive(1'b0, 1'b0, 8'h00, 24'h0);
        cycle(1'b0, 1'b0, 24'h0, 1'b0);

        // Continuous contention: CCCCD repeated three times.
        cpu_drive(1'b1, 1'b0, 8'h03, 24'h0);
        dbg_drive(1'b1, 1'b0, 8'h02, 24'h0);
        for (int i = 0; i < 15; i++) begin
            if (i % 5 == 4) cycle(1'b0, 1'b1, 24'h000022, 1'b1);
            else            cycle(1'b1, 1'b0, 24'h000033, 1'b1);
        end
        cpu_drive(1'b0, 1'b0, 8'h00, 24'h0);
        dbg_drive(1'b0, 1'b0, 8'h00, 24'h0);
        cycle(1'b0, 1'b0, 24'h0, 1'b0);

        // CPU read returns in the same cycle a debug read is granted.
        cpu_drive(1'b1, 1'b0, 8'h01, 24'h0);
        cycle(1'b1, 1'b0, 24'h000011, 1'b1);
        cpu_drive(1'b0, 1'b0, 8'h00, 24'h0);
        dbg_drive(1'b1, 1'b0, 8'h02, 24'h0);
        cycle(1'b0, 1'b1, 24'h000022, 1'b1);
        dbg_drive(1'b0, 1'b0, 8'h00, 24'h0);
        cycle(1'b0, 1'b0, 24'h0, 1'b0);

        // Debug drops its request after 3 denials: the count restarts.
        cpu_drive(1'b1, 1'b0, 8'h03, 24'h0);
        dbg_drive(1'b1, 1'b0, 8'h02, 24'h0);
        repeat (3) cycle(1'b1, 1'b0, 24'h000033, 1'b1);
        dbg_req = 1'b0;
        cycle(1'b1, 1'b0, 24'h000033, 1'b1);
        dbg_req = 1'b1;
        repeat (4) cycle(1'b1, 1'b0, 24'h000033, 1'b1);
        cycle(1'b0, 1'b1, 24'h000022, 1'b1);

        // Reset with contention in progress: the last pre-reset read is
        // dropped and the starvation count starts over afterwards.
        repeat (2) cycle(1'b1, 1'b0, 24'h000033, 1'b1);
        cycle(1'b1, 1'b0, 24'h000033, 1'b0);
        rst_n = 1'b0;
        repeat (2) cycle(1'b0, 1'b0, 24'h0, 1'b0);
        rst_n = 1'b1;
        repeat (4) cycle(1'b1, 1'b0, 24'h000033, 1'b1);
        cycle(1'b0, 1'b1, 24'h000022, 1'b1);
        cpu_drive(1'b0, 1'b0, 8'h00, 24'h0);

        // Debug read granted, then reset on the next edge: no dbg_rvalid.
        cycle(1'b0, 1'b1, 24'h000022, 1'b0);
        rst_n = 1'b0;
        dbg_drive(1'b0, 1'b0, 8'h00, 24'h0);
        cycle(1'b0, 1'b0, 24'h0, 1'b0);
        rst_n = 1'b1;
        repeat (2) cycle(1'b0, 1'b0, 24'h0, 1'b0);

        check("sb_drain", 64'(sb.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port, 24-bit-wide data memory between the CPU load/store unit and the debug/dump port used to read data words such as mem0..mem18. The CPU has fixed priority. A starvation counter guarantees the debug port a slot within a bounded number of cycles. The block sits between the CPU core, the debug port and the data memory, and routes synchronous-read data back to whichever requester issued the read.

## Interface
- DATA_W, 24, data word width
- ADDR_W, 8, word address width
- STARVE_LIMIT, 4, consecutive denied debug-request cycles before debug is forced through (must be ≥1)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU request accepted this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as the cpu_* ports, for the debug port
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0

## Operation
- At most one memory access per cycle. Requesters hold req, we, addr and wdata stable until they see gnt high.
- Grant (combinational, same cycle):
  - force = (starve_cnt == STARVE_LIMIT).
  - dbg_gnt = dbg_req & (~cpu_req | force).
  - cpu_gnt = cpu_req & ~dbg_gnt.
- Memory command (combinational): mem_* carry the fields of the granted requester, and mem_en = cpu_gnt | dbg_gnt.
  - When nothing is granted: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Starvation counter (registered, width clog2(STARVE_LIMIT+1)):
  - Increments when dbg_req=1 and dbg_gnt=0.
  - Clears on dbg_gnt or when dbg_req=0.
  - Saturates at STARVE_LIMIT; it cannot exceed it, because force grants debug that cycle.
- Read return tracking:
  - Registered rd_pend (1 bit) and rd_owner (0 = CPU, 1 = DBG).
  - On a granted read, rd_pend<=1 and rd_owner<=the requester; otherwise rd_pend<=0.
  - rvalid of the owner = rd_pend. The owner's rdata = mem_rdata; the other port's rdata = 0.
- Writes produce gnt only, never rvalid.
- Back-to-back reads from either port, or from alternating ports, are fully pipelined: one rvalid per cycle.
- A requester may issue its next request in the cycle its rvalid arrives.

## Timing
- Reset (rst_n=0 at a clock edge):
  - starve_cnt=0, rd_pend=0, rd_owner=0.
  - cpu_rvalid=dbg_rvalid=0 and both rdata=0 from the following cycle.
  - A read granted in the cycle before reset never returns rvalid.
  - While rst_n=0, grants are suppressed: gnt=0 and mem_en=0.
- Latency:
  - Grant: 0 cycles after req with no contention.
  - Read data: rvalid exactly 1 cycle after gnt.
  - Write: committed by memory at the edge ending the gnt cycle.
- Contention, with both requesters held continuously:
  - CPU gets STARVE_LIMIT grants, then debug gets 1, and the pattern repeats.
  - Debug worst-case wait is STARVE_LIMIT cycles.
- Simultaneous events:
  - A debug read granted in the same cycle the CPU's earlier read returns: cpu_rvalid that cycle, dbg_rvalid the next.
  - A write and a read to the same address on consecutive cycles: the read returns the new data (the memory handles this).
- The counter is unaffected by CPU-only traffic.

## Structure
- Shared package dmem_pkg holds:
  - DATA_W and ADDR_W defaults;
  - requester ID constants REQ_CPU=1'b0 and REQ_DBG=1'b1, used for rd_owner and shared with the debug block.
- One natural sub-module, starve_cnt: a saturating counter with inputs inc and clr, parameter LIMIT, and output at_limit.
- Everything else (grant logic, mux, read tracking) stays flat in dmem_arbiter.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with cpu_req=1 -> cpu_gnt=0, mem_en=0, both rvalid=0. After release, the first CPU read of addr 0x03 gets gnt the same cycle and rvalid next cycle with the memory word at 0x03.
- CPU-only traffic: write 0x00ABCD to addr 5, then read addr 5 -> gnt on both cycles; cpu_rvalid in the cycle after the read gnt with cpu_rdata=0x00ABCD; dbg_rvalid stays 0.
- Contention with STARVE_LIMIT=4, both requesting reads continuously for 15 cycles -> grant sequence CCCCD CCCCD CCCCD; dbg_gnt on cycles 4, 9 and 14 (0-based); every rvalid goes to the correct port one cycle later.
- Interleaved returns: CPU read addr 1 (data 0x000011) in cycle n; debug read addr 2 (data 0x000022) with CPU idle in cycle n+1 -> cpu_rdata=0x000011 at n+1, dbg_rdata=0x000022 at n+2, never swapped.
- Reset mid-operation: grant a debug read, then assert rst_n=0 on the next edge -> dbg_rvalid never goes high and starve_cnt=0.
- Debug drops its request: debug requests for 3 denied cycles, drops for 1 cycle, then re-requests -> the counter restarts from 0, so the first debug grant comes 4 cycles after the re-request.
